mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 18 +
 rtl/mem_wb_stage_retire_counter.sv | 34 +++
 rtl/mem_wb_stage.sv | 93 +++++++++
 tb/tb_mem_wb_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions used by the EX, MEM and WB pipeline stages.
package mem_wb_stage_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 5;
  localparam int CPU_X0_IDX = 0;

  // Write-back source select carried through MEM/WB.
  typedef enum logic [0:0] {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  function automatic wb_src_e to_wb_src(input logic mem_to_reg);
    return mem_to_reg ? WB_SRC_MEM : WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/mem_wb_stage_retire_counter.sv
// Free-running retired-instruction counter; wraps silently, clear beats increment.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux, x0 write suppression and retire count.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic              cnt_clear,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retired
);

  logic              valid_q,      valid_d;
  logic              reg_write_q,  reg_write_d;
  wb_src_e           wb_src_q,     wb_src_d;
  logic [REG_AW-1:0] rd_q,         rd_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] read_data_q,  read_data_d;
  logic              advance;

  assign advance = !stall && !flush;

  // Flush only squashes the valid bit; the payload fields are left as they were.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    wb_src_d     = wb_src_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d      = valid_in;
      reg_write_d  = reg_write_in;
      wb_src_d     = to_wb_src(mem_to_reg_in);
      rd_d         = rd_in;
      alu_result_d = alu_result_in;
      read_data_d  = read_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      wb_src_q     <= WB_SRC_ALU;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      wb_src_q     <= wb_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
    end
  end

  assign wb_valid  = valid_q;
  assign wb_we     = valid_q && reg_write_q && (rd_q != REG_AW'(CPU_X0_IDX));
  assign wb_rd     = rd_q;
  assign wb_data   = (wb_src_q == WB_SRC_MEM) ? read_data_q : alu_result_q;
  assign fwd_valid = wb_we;

  // Counting on entry (not while resident) keeps stalled instructions from double counting.
  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (valid_in && advance),
    .clr   (cnt_clear),
    .count (retired)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a 32-bit-counter and a 4-bit-counter instance share all stimulus.
module tb_mem_wb_stage;

  localparam int OBS_W = 76;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_result_in;
  logic [31:0] read_data_in;
  logic        cnt_clear;

  logic        wb_valid, wb_we, fwd_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] retired;
  logic        wb_valid4, wb_we4, fwd_valid4;
  logic [4:0]  wb_rd4;
  logic [31:0] wb_data4;
  logic [3:0]  retired4;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .rd_in(rd_in),
    .alu_result_in(alu_result_in), .read_data_in(read_data_in), .cnt_clear(cnt_clear),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .retired(retired)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .rd_in(rd_in),
    .alu_result_in(alu_result_in), .read_data_in(read_data_in), .cnt_clear(cnt_clear),
    .wb_valid(wb_valid4), .wb_we(wb_we4), .wb_rd(wb_rd4), .wb_data(wb_data4),
    .fwd_valid(fwd_valid4), .retired(retired4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] exp_v;
  int n_vec;
  int n_err;

  assign obs = {wb_valid, wb_we, fwd_valid, wb_rd, wb_data, retired, retired4};

  // Reference model of the architectural WB state.
  logic        m_valid, m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdat, m_cnt;

  function automatic logic [OBS_W-1:0] model_out();
    logic we;
    we = m_valid && m_rw && (m_rd != 5'd0);
    return {m_valid, we, we, m_rd, (m_m2r ? m_rdat : m_alu), m_cnt, m_cnt[3:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdat, input logic clr);
    rst_n = r; stall = s; flush = f; valid_in = v; reg_write_in = rw;
    mem_to_reg_in = m2r; rd_in = rd; alu_result_in = alu; read_data_in = rdat;
    cnt_clear = clr;
    if (!r) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_rdat = 0; m_cnt = 0;
    end else begin
      if (clr) m_cnt = 0;
      else if (!s && !f && v) m_cnt = m_cnt + 1;
      if (f) m_valid = 0;
      else if (!s) begin
        m_valid = v; m_rw = rw; m_m2r = m2r; m_rd = rd; m_alu = alu; m_rdat = rdat;
      end
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 1, 1, 1, 5'd3, 32'h55, 32'h66, 1);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL reset[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
    n_vec++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_zero: got %h want 0", obs);
    end
  endtask

  task automatic test_load();
    drive(1, 0, 0, 1, 1, 1, 5'd5, 32'h40, 32'hDEADBEEF, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL load: got %h want %h", obs, exp_v);
    end
    n_vec++;
    if ({wb_we, wb_rd, wb_data, retired} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'd1}) begin
      n_err++; $display("FAIL load_direct: got we=%b rd=%0d data=%h ret=%0d want 1/5/deadbeef/1",
                        wb_we, wb_rd, wb_data, retired);
    end
  endtask

  task automatic test_alu_x0();
    drive(1, 0, 0, 1, 1, 0, 5'd0, 32'h1234, 32'hFFFF0000, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL alu_x0: got %h want %h", obs, exp_v);
    end
    n_vec++;
    if ({wb_data, wb_valid, wb_we, fwd_valid} !== {32'h1234, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL alu_x0_direct: got data=%h v=%b we=%b fwd=%b want 1234/1/0/0",
                        wb_data, wb_valid, wb_we, fwd_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] base;
    drive(1, 0, 0, 1, 1, 1, 5'd7, 32'h99, 32'h11, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL stall_load: got %h want %h", obs, exp_v);
    end
    base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 1, 1, 5'd9, 32'h98, 32'h22, 0);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v || wb_rd !== 5'd7 || wb_data !== 32'h11 || retired !== base) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_flush_stall();
    logic [31:0] base;
    base = m_cnt;
    drive(1, 1, 1, 1, 1, 0, 5'd12, 32'h77, 32'h88, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v || wb_valid !== 1'b0 || wb_we !== 1'b0 || retired !== base) begin
      n_err++; $display("FAIL flush_stall: got %h want %h", obs, exp_v);
    end
    drive(1, 0, 1, 1, 1, 0, 5'd13, 32'h78, 32'h89, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL flush_only: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_bubble_store();
    drive(1, 0, 0, 0, 1, 0, 5'd4, 32'hAB, 32'hCD, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v || wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      n_err++; $display("FAIL bubble: got %h want %h", obs, exp_v);
    end
    drive(1, 0, 0, 1, 0, 0, 5'd4, 32'h1000, 32'h0, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v || wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      n_err++; $display("FAIL store: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_wrap_clear();
    drive(1, 0, 0, 1, 1, 0, 5'd2, 32'h5, 32'h6, 1);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v || retired !== 32'd0 || retired4 !== 4'd0) begin
      n_err++; $display("FAIL clear_vs_inc: got %h want %h", obs, exp_v);
    end
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 0, 1, 1, 0, 5'(i), 32'(i * 3), 32'h0, 0);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v || retired4 !== 4'(i)) begin
        n_err++; $display("FAIL wrap[%0d]: got %h want %h ret4=%0d", i, obs, exp_v, retired4);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 1, 0, 5'd1, 32'h1, 32'h0, 1);
    exp_v = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 2 ? 1'b0 : 1'b0, 0, 1, 1, 0, 5'd3, 32'hC0DE, 32'h0, 0);
      exp_v = exp_q.pop_front();
    end
    drive(1, 1, 0, 1, 1, 0, 5'd6, 32'hBAD, 32'h0, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v || wb_valid !== 1'b1 || retired !== 32'd3) begin
      n_err++; $display("FAIL pre_reset: got %h want %h", obs, exp_v);
    end
    drive(0, 1, 0, 1, 1, 0, 5'd6, 32'hBAD, 32'h0, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v || obs !== '0) begin
      n_err++; $display("FAIL reset_mid: got %h want %h", obs, exp_v);
    end
    drive(1, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    exp_v = exp_q.pop_front();
    n_vec++;
    if (obs !== exp_v || retired !== 32'd0) begin
      n_err++; $display("FAIL post_reset: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, $urandom,
            1'($urandom_range(0, 9) == 0));
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 0; stall = 0; flush = 0; valid_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    rd_in = 0; alu_result_in = 0; read_data_in = 0; cnt_clear = 0;
    m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_rdat = 0; m_cnt = 0;
    #2;
    test_reset();
    test_load();
    test_alu_x0();
    test_stall();
    test_flush_stall();
    test_bubble_store();
    test_wrap_clear();
    test_reset_mid();
    test_random();
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
